// File: rtl/contador_dec_recarga.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse.
// Supports one-shot (stops in FIN) and auto-reload operation.
module contador_dec_recarga #(
    parameter int unsigned n           = 8,
    parameter bit          AUTO_RELOAD = 1'b1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic [n-1:0] i_Valor,
    input  logic         i_Start,
    input  logic         i_Stop,
    input  logic         i_Dec,
    output logic [n-1:0] o_Cta,
    output logic         o_Cero,
    output logic         o_Activo
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CUENTA = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;

    localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};
    localparam logic [n-1:0] ZERO = '0;

    logic [1:0]   state_reg, state_next;
    logic [n-1:0] cta_reg, cta_next;
    logic [n-1:0] recarga_reg, recarga_next;
    logic         cero_reg, cero_next;
    logic         activo_reg;

    always_comb begin
        state_next   = state_reg;
        cta_next     = cta_reg;
        recarga_next = recarga_reg;
        cero_next    = 1'b0;

        if (i_Load) begin
            recarga_next = i_Valor;
            cta_next     = i_Valor;
            state_next   = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_Start && (cta_reg != ZERO)) begin
                        state_next = CUENTA;
                    end
                end
                CUENTA: begin
                    if (i_Stop) begin
                        state_next = IDLE;
                    end else if (i_Dec) begin
                        // A zero count in CUENTA is unreachable, but guard it so the count can never wrap
                        if (cta_reg > ONE) begin
                            cta_next = cta_reg - ONE;
                        end else if (cta_reg == ONE) begin
                            cero_next = 1'b1;
                            if (AUTO_RELOAD) begin
                                cta_next = recarga_reg;
                            end else begin
                                cta_next   = ZERO;
                                state_next = FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    if (i_Start && (recarga_reg != ZERO)) begin
                        cta_next   = recarga_reg;
                        state_next = CUENTA;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg   <= IDLE;
            cta_reg     <= ZERO;
            recarga_reg <= ZERO;
            cero_reg    <= 1'b0;
            activo_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cta_reg     <= cta_next;
            recarga_reg <= recarga_next;
            cero_reg    <= cero_next;
            // Decoded from the next state so o_Activo is a plain flop output
            activo_reg  <= (state_next == CUENTA);
        end
    end

    assign o_Cta    = cta_reg;
    assign o_Cero   = cero_reg;
    assign o_Activo = activo_reg;

endmodule

// File: tb/tb_contador_dec_recarga.sv
// Directed bench for contador_dec_recarga: auto-reload (n=8), one-shot (n=8)
// and a 4-bit auto-reload instance, all driven from shared inputs.
module tb_contador_dec_recarga;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, start, stop, dec;
    logic [7:0] valor;

    logic [7:0] cta_a, cta_o;
    logic [3:0] cta_w;
    logic       cero_a, cero_o, cero_w;
    logic       activo_a, activo_o, activo_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    contador_dec_recarga #(.n(8), .AUTO_RELOAD(1'b1)) dut_auto (
        .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Valor(valor),
        .i_Start(start), .i_Stop(stop), .i_Dec(dec),
        .o_Cta(cta_a), .o_Cero(cero_a), .o_Activo(activo_a)
    );

    contador_dec_recarga #(.n(8), .AUTO_RELOAD(1'b0)) dut_oneshot (
        .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Valor(valor),
        .i_Start(start), .i_Stop(stop), .i_Dec(dec),
        .o_Cta(cta_o), .o_Cero(cero_o), .o_Activo(activo_o)
    );

    contador_dec_recarga #(.n(4), .AUTO_RELOAD(1'b1)) dut_w4 (
        .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Valor(valor[3:0]),
        .i_Start(start), .i_Stop(stop), .i_Dec(dec),
        .o_Cta(cta_w), .o_Cero(cero_w), .o_Activo(activo_w)
    );

    typedef struct {
        int         sel;      // 0 = auto n=8, 1 = one-shot n=8
        logic       load;
        logic [7:0] valor;
        logic       start;
        logic       stop;
        logic       dec;
        logic [7:0] cta;
        logic       cero;
        logic       activo;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic l, input logic [7:0] v, input logic s, input logic p, input logic d);
        @(negedge clk);
        load  = l;
        valor = v;
        start = s;
        stop  = p;
        dec   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int sel, input logic l, input logic [7:0] v, input logic s,
                       input logic p, input logic d, input logic [7:0] c, input logic z, input logic a);
        vec_t r;
        r.sel = sel; r.load = l; r.valor = v; r.start = s; r.stop = p; r.dec = d;
        r.cta = c; r.cero = z; r.activo = a;
        tbl.push_back(r);
    endtask

    initial begin
        logic [7:0] got_cta;
        logic       got_cero, got_act;
        logic [7:0] exp_w;

        // Auto-reload 3: count 3,2,1,3,2,1,3 with pulses after each 1->3
        add(0, 1, 3, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 1, 2, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 3, 1, 1);
        add(0, 0, 0, 0, 0, 1, 2, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 3, 1, 1);
        add(0, 0, 0, 0, 0, 1, 2, 0, 1);
        // One-shot 2: expire into FIN, FIN ignores Dec/Stop, Start reloads
        add(1, 1, 2, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 1, 0, 0, 2, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 2, 0, 1);
        // Pause/resume: Stop beats Dec, Dec ignored in IDLE
        add(0, 1, 5, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 1, 0, 0, 5, 0, 1);
        add(0, 0, 0, 0, 0, 1, 4, 0, 1);
        add(0, 0, 0, 0, 0, 1, 3, 0, 1);
        add(0, 0, 0, 0, 1, 1, 3, 0, 0);
        add(0, 0, 0, 0, 0, 1, 3, 0, 0);
        add(0, 0, 0, 1, 0, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 1, 2, 0, 1);
        // Load 0 then Start stays IDLE
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Load beats Dec while counting at 4
        add(0, 1, 5, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 1, 0, 0, 5, 0, 1);
        add(0, 0, 0, 0, 0, 1, 4, 0, 1);
        add(0, 1, 9, 0, 0, 1, 9, 0, 0);
        add(0, 0, 0, 0, 0, 1, 9, 0, 0);
        // Reload 1: every Dec pulses, count stays 1
        add(0, 1, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1, 1, 1);

        rst = 1'b1; load = 0; valor = 0; start = 0; stop = 0; dec = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cta", cta_a, 8'd0);
        check("reset_cero", {7'd0, cero_a}, 8'd0);
        check("reset_activo", {7'd0, activo_a}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].load, tbl[i].valor, tbl[i].start, tbl[i].stop, tbl[i].dec);
            if (tbl[i].sel == 0) begin
                got_cta = cta_a; got_cero = cero_a; got_act = activo_a;
            end else begin
                got_cta = cta_o; got_cero = cero_o; got_act = activo_o;
            end
            check($sformatf("vec%0d_cta", i), got_cta, tbl[i].cta);
            check($sformatf("vec%0d_cero", i), {7'd0, got_cero}, {7'd0, tbl[i].cero});
            check($sformatf("vec%0d_activo", i), {7'd0, got_act}, {7'd0, tbl[i].activo});
            $display("vec %0d: sel=%0d ld=%0b v=%0d st=%0b sp=%0b dc=%0b -> cta=%0d cero=%0b act=%0b",
                     i, tbl[i].sel, tbl[i].load, tbl[i].valor, tbl[i].start, tbl[i].stop,
                     tbl[i].dec, got_cta, got_cero, got_act);
        end

        // Asynchronous reset mid-count: outputs clear before any edge
        apply(1, 7, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1);
        check("pre_rst_cta", cta_a, 8'd6);
        @(negedge clk);
        dec = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_cta", cta_a, 8'd0);
        check("async_rst_activo", {7'd0, activo_a}, 8'd0);
        check("async_rst_cero", {7'd0, cero_a}, 8'd0);
        start = 1; dec = 1; load = 0;
        @(posedge clk);
        #1;
        check("rst_held_cta", cta_a, 8'd0);
        check("rst_held_activo", {7'd0, activo_a}, 8'd0);
        @(negedge clk);
        rst = 1'b0; start = 0; dec = 0;
        apply(0, 0, 1, 0, 0);
        check("post_rst_start_activo", {7'd0, activo_a}, 8'd0);
        check("post_rst_start_cta", cta_a, 8'd0);
        $display("reset sequence: cta=%0d act=%0b", cta_a, activo_a);

        // 4-bit width boundary: 15 down to 1, then reload to 15
        apply(1, 15, 0, 0, 0);
        check("w4_load", {4'd0, cta_w}, 8'd15);
        apply(0, 0, 1, 0, 0);
        check("w4_activo", {7'd0, activo_w}, 8'd1);
        for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 0, 0, 1);
            exp_w = (i < 15) ? 8'(15 - i) : ((i == 15) ? 8'd15 : 8'd14);
            check($sformatf("w4_dec%0d_cta", i), {4'd0, cta_w}, exp_w);
            check($sformatf("w4_dec%0d_cero", i), {7'd0, cero_w}, {7'd0, (i == 15)});
            vectors++;
            if (cta_w == 4'd0) begin
                miscompares++;
                $display("FAIL w4_range: got %0d expected 1..15", cta_w);
            end
            $display("w4 dec %0d: cta=%0d cero=%0b", i, cta_w, cero_w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
